seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Display-side consumer of the BCD digit buses produced by the game timer and score logic. It latches four 4-bit BCD codes once per scan frame, decodes them to active-low seven-segment patterns, and time-multiplexes them onto a 4-digit common-anode display. It adds an anti-ghosting guard interval per digit slot and an optional frame-synchronous blink. It sits between the game/timer datapath and the board's AN/SEG pins.

## Interface
- SCAN_CYCLES, 100000, clock cycles per digit slot (≥ 2)
- GUARD_CYCLES, 2, cycles at the start of each slot with all anodes off (1 ≤ GUARD_CYCLES < SCAN_CYCLES)
- BLINK_FRAMES, 64, full scan frames per blink half-period (≥ 1)
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- BCD0  input  4  rightmost digit code
- BCD1  input  4  digit 1 code
- BCD2  input  4  digit 2 code
- BCD3  input  4  leftmost digit code
- blink  input  1  1 = blank all digits during the blink off-phase
- DIGIT  output  4  active-low anode enables; DIGIT[i] drives digit i
- DISPLAY  output  7  active-low segments {g,f,e,d,c,b,a}

## Operation
- Codes: 0–9 decode to decimal digits; 10 = blank; 11 = dash (g only); 12–15 = blank.
- Patterns (DISPLAY): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111, blank=1111111.
- Slot counter cnt: 0..SCAN_CYCLES-1, increments every cycle, wraps to 0.
- Digit index idx: 0→1→2→3→0; advances on the cycle where cnt == SCAN_CYCLES-1.
- Frame latch: on the edge ending a cycle with cnt == 0 and idx == 0, BCD0..BCD3 are copied into four shadow registers. Inputs are ignored at all other times, so changes mid-frame never tear.
- Frame counter: increments at the end of each frame (idx == 3, cnt == SCAN_CYCLES-1). When it reaches BLINK_FRAMES-1 it wraps to 0 and blink phase toggles. Phase 0 = visible.
- Output function of the current cycle's (cnt, idx, shadow, phase, blink):
  - If cnt < GUARD_CYCLES, or blink == 1 and phase == 1: DIGIT = 1111 and DISPLAY = 1111111.
  - Otherwise DIGIT = ~(1 << idx) and DISPLAY = decode(shadow[idx]).
- blink is used live (not latched). Deasserting it during the off-phase restores the display at the next output update.
- Blank codes still drive the anode. Only the segments are off.

## Timing
- DIGIT and DISPLAY are registered and lag the internal cnt/idx by exactly one cycle.
- Reset (applied on any edge with rst = 1, including mid-frame), applied at that edge:
  - cnt = 0, idx = 0, frame counter = 0, phase = 0
  - all shadows = 10 (blank)
  - DIGIT = 1111, DISPLAY = 1111111
- With cycle n = 0 as the first cycle with rst low:
  - cnt(n) = n mod SCAN_CYCLES
  - idx(n) = (n / SCAN_CYCLES) mod 4
  - Inputs are latched at the end of cycle 0.
  - Cycle n+1 outputs reflect cycle n state.
- Each slot is visible as GUARD_CYCLES all-off cycles followed by SCAN_CYCLES-GUARD_CYCLES lit cycles. A frame is 4·SCAN_CYCLES cycles.
- Input-to-display latency: the value sampled at frame start first appears GUARD_CYCLES+1 cycles later on digit 0. Digit i appears i·SCAN_CYCLES later than digit 0.
- Because GUARD_CYCLES ≥ 1, a shadow update is never visible during a lit cycle of the previous frame's data.
- Simultaneous frame end and blink-phase toggle: the new phase applies from the next frame's first output update.

## Test plan
- Parameters for all scenarios: SCAN_CYCLES=4, GUARD_CYCLES=1, BLINK_FRAMES=2.
- Reset: hold rst 3 cycles with arbitrary inputs -> DIGIT=1111, DISPLAY=1111111 during reset and during the first cycle after release.
- Scan order: BCD3..0 = 1,2,3,5, blink=0 ->
  - cycle 1: all off
  - cycles 2–4: DIGIT=1110, DISPLAY=0010010
  - cycle 5: off
  - cycles 6–8: DIGIT=1101, DISPLAY=0110000
  - then DIGIT=1011 with 0100100, then DIGIT=0111 with 1111001
  - wraps to DIGIT=1110 at cycle 18
- Frame atomicity: change BCD0 from 5 to 8 at cycle 3 -> digit 0 shows 0010010 until the next frame; it shows 0000000 from cycle 18.
- Codes 10–15: drive BCD0 through 10..15 one frame each -> DIGIT=1110 on lit cycles. DISPLAY=0111111 for 11 only; 1111111 for the others.
- Blink: blink=1 -> frames 0–1 visible, frames 2–3 DIGIT=1111 throughout, frames 4–5 visible. Dropping blink during frame 2 restores output on the next lit cycle.
- Mid-frame reset: assert rst at cycle 10 for 1 cycle -> outputs all off next cycle. The scan restarts at digit 0 and inputs are re-latched, exactly as after power-on reset.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode scanner: latches BCD codes once per frame, decodes them to
// active-low segments and multiplexes the anodes with a per-slot guard and optional blink.
module seven_seg_scanner #(
  parameter int SCAN_CYCLES  = 100000,
  parameter int GUARD_CYCLES = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] BCD0,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD3,
  input  logic       blink,
  output logic [3:0] DIGIT,
  output logic [6:0] DISPLAY
);

  localparam int CW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
  localparam int FW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_GUARD  = CW'(GUARD_CYCLES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [3:0]    CODE_BLANK = 4'd10;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [FW-1:0] frame_cnt;
  logic          phase;
  logic [3:0]    shadow [4];

  logic          slot_end;
  logic          frame_end;
  logic          latch_en;
  logic          dark;
  logic [3:0]    digit_nxt;
  logic [6:0]    display_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      4'd11:   seg = 7'b0111111;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  always_comb begin
    slot_end    = (cnt == CNT_LAST);
    frame_end   = slot_end && (idx == 2'd3);
    latch_en    = (cnt == '0) && (idx == 2'd0);
    dark        = (cnt < CNT_GUARD) || (blink && phase);
    digit_nxt   = 4'b1111;
    display_nxt = 7'b1111111;
    if (!dark) begin
      digit_nxt   = ~(4'b0001 << idx);
      display_nxt = seg_decode(shadow[idx]);
    end
  end

  // Outputs are registered from the current cycle's state, giving the one-cycle lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= 2'd0;
      frame_cnt <= '0;
      phase     <= 1'b0;
      for (int i = 0; i < 4; i++) shadow[i] <= CODE_BLANK;
      DIGIT     <= 4'b1111;
      DISPLAY   <= 7'b1111111;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= idx + 2'd1;
      if (frame_end) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      if (latch_en) begin
        shadow[0] <= BCD0;
        shadow[1] <= BCD1;
        shadow[2] <= BCD2;
        shadow[3] <= BCD3;
      end
      DIGIT   <= digit_nxt;
      DISPLAY <= display_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a cycle-indexed arithmetic model pushes the
// expected next-cycle outputs, and an independent monitor pops and compares every cycle.
module tb_seven_seg_scanner;

  localparam int S  = 4;
  localparam int G  = 1;
  localparam int BF = 2;
  localparam int FR = 4 * S;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bcd0, bcd1, bcd2, bcd3;
  logic       blink;
  logic [3:0] DIGIT;
  logic [6:0] DISPLAY;

  typedef struct packed {
    logic [3:0] d;
    logic [6:0] s;
  } exp_t;

  exp_t       q [$];
  int         checks   = 0;
  int         failures = 0;
  int         n        = 0;
  logic [3:0] sh [4];
  bit         done     = 1'b0;

  seven_seg_scanner #(
    .SCAN_CYCLES (S),
    .GUARD_CYCLES(G),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .BCD0   (bcd0),
    .BCD1   (bcd1),
    .BCD2   (bcd2),
    .BCD3   (bcd3),
    .blink  (blink),
    .DIGIT  (DIGIT),
    .DISPLAY(DISPLAY)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] code);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b1111111, 7'b0111111,
          7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
    return t[code];
  endfunction

  // One cycle: predict the outputs the coming edge will register, then advance time.
  task automatic tick();
    exp_t       e;
    int         c, ix, ph;
    logic [3:0] one;
    one = 4'b0001;
    e.d = 4'b1111;
    e.s = 7'b1111111;
    if (rst) begin
      n = 0;
      for (int i = 0; i < 4; i++) sh[i] = 4'd10;
    end else begin
      c  = n % S;
      ix = (n / S) % 4;
      ph = ((n / FR) / BF) % 2;
      if (!(c < G || (blink && ph == 1))) begin
        e.d = ~(one << ix);
        e.s = seg_of(sh[ix]);
      end
      if (n % FR == 0) begin
        sh[0] = bcd0; sh[1] = bcd1; sh[2] = bcd2; sh[3] = bcd3;
      end
      n++;
    end
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic check_off(input string tag);
    checks++;
    if (DIGIT !== 4'b1111 || DISPLAY !== 7'b1111111) begin
      failures++;
      $display("FAIL %s t=%0t DIGIT=%b DISPLAY=%b expected all off",
               tag, $time, DIGIT, DISPLAY);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check_off("reset_hold");
    rst = 1'b0;
  endtask

  task automatic rand_bcd();
    bcd0 = 4'($urandom_range(0, 15));
    bcd1 = 4'($urandom_range(0, 15));
    bcd2 = 4'($urandom_range(0, 15));
    bcd3 = 4'($urandom_range(0, 15));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #4;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (DIGIT !== e.d || DISPLAY !== e.s) begin
          failures++;
          $display("FAIL scan t=%0t DIGIT=%b DISPLAY=%b expected DIGIT=%b DISPLAY=%b",
                   $time, DIGIT, DISPLAY, e.d, e.s);
        end
      end
    end
  end

  initial begin : watchdog
    repeat (200000) @(posedge clk);
    if (!done) begin
      failures++;
      $display("FAIL timeout t=%0t stimulus did not complete", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin : driver
    rst   = 1'b1;
    blink = 1'b0;
    rand_bcd();
    #2;
    repeat (3) begin
      rand_bcd();
      tick();
      check_off("reset_hold");
    end
    rst = 1'b0;

    // scan order, then a mid-frame BCD0 change that must wait for the next frame
    bcd3 = 4'd1; bcd2 = 4'd2; bcd1 = 4'd3; bcd0 = 4'd5;
    for (int k = 0; k < 2 * FR; k++) begin
      if (k == 3) bcd0 = 4'd8;
      tick();
      if (k == 0) check_off("reset_release");
    end

    do_reset();
    for (int v = 10; v <= 15; v++) begin
      bcd0 = 4'(v);
      repeat (FR) tick();
    end

    do_reset();
    rand_bcd();
    blink = 1'b1;
    repeat (6 * FR) tick();

    do_reset();
    blink = 1'b1;
    for (int k = 0; k < 4 * FR; k++) begin
      if (k == 2 * FR + 5) blink = 1'b0;
      tick();
    end

    do_reset();
    rand_bcd();
    for (int k = 0; k < 3 * FR; k++) begin
      rst = (k == 10);
      if (k == 12) rand_bcd();
      tick();
      if (k == 10) check_off("mid_frame_reset");
    end
    rst = 1'b0;

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) rand_bcd();
      if ($urandom_range(0, 99) == 0) blink = ~blink;
      rst = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (2) tick();

    repeat (2) @(posedge clk);
    #5;
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
